// File: rtl/watch_report_pkg.sv
// Shared constants and state encoding for the watch time reporter.
package watch_report_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int FRAME_LEN_FULL  = 13;
    localparam int FRAME_LEN_SHORT = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SEND    = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_99.sv
// Two-digit binary to BCD converter; inputs above 99 saturate to 99.
module bin2bcd_99 (
    input  logic [6:0] i_bin,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones
);

    function automatic logic [6:0] sat99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    logic [6:0] val;

    // Saturate first, then split into tens and ones.
    always_comb begin
        val    = sat99(i_bin);
        o_tens = 4'(val / 7'd10);
        o_ones = 4'(val % 7'd10);
    end

endmodule

// File: rtl/watch_time_reporter.sv
// Snapshots the watch time and streams it as "HH:MM:SS[.CC]\r\n" to a UART TX byte port.
module watch_time_reporter
    import watch_report_pkg::*;
#(
    parameter bit SEND_CSEC = 1'b1,
    parameter bit AUTO_SEC  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_report,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [6:0] i_msec,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic       o_overrun
);

    localparam logic [3:0] LAST_IDX = SEND_CSEC ? 4'(FRAME_LEN_FULL - 1)
                                                : 4'(FRAME_LEN_SHORT - 1);

    state_t     state_q, state_d;
    logic       pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic [3:0] idx_q, idx_d;
    logic [5:0] prev_sec_q, prev_sec_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic [6:0] msec_q, msec_d;
    // Digit order: H10 H1 M10 M1 S10 S1 C10 C1
    logic [3:0] dig_q [8];
    logic [3:0] dig_d [8];
    logic [3:0] bcd   [8];

    logic       req;
    logic       xfer;
    logic       last_xfer;
    logic [3:0] byte_idx;
    logic [7:0] frame_byte;

    bin2bcd_99 u_bcd_hour (.i_bin({2'b00, hour_q}), .o_tens(bcd[0]), .o_ones(bcd[1]));
    bin2bcd_99 u_bcd_min  (.i_bin({1'b0, min_q}),   .o_tens(bcd[2]), .o_ones(bcd[3]));
    bin2bcd_99 u_bcd_sec  (.i_bin({1'b0, sec_q}),   .o_tens(bcd[4]), .o_ones(bcd[5]));
    bin2bcd_99 u_bcd_msec (.i_bin(msec_q),          .o_tens(bcd[6]), .o_ones(bcd[7]));

    assign req       = i_report | (AUTO_SEC & (i_sec != prev_sec_q));
    assign xfer      = (state_q == SEND) & i_tx_ready;
    assign last_xfer = xfer & (idx_q == LAST_IDX);

    // Control registers: state, pending flag, overrun pulse and byte index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            idx_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            idx_q     <= idx_d;
        end
    end

    // Data registers: previous second, input snapshot and BCD digits (no reset needed).
    always_ff @(posedge clk) begin
        prev_sec_q <= prev_sec_d;
        hour_q     <= hour_d;
        min_q      <= min_d;
        sec_q      <= sec_d;
        msec_q     <= msec_d;
        dig_q      <= dig_d;
    end

    // Next-state logic: snapshot, conversion, byte stepping and request queuing.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        overrun_d  = 1'b0;
        idx_d      = idx_q;
        prev_sec_d = i_sec;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        msec_d     = msec_q;
        dig_d      = dig_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    hour_d  = i_hour;
                    min_d   = i_min;
                    sec_d   = i_sec;
                    msec_d  = i_msec;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                dig_d   = bcd;
                idx_d   = 4'd0;
                state_d = SEND;
                if (req) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
            end
            SEND: begin
                if (last_xfer) begin
                    idx_d = 4'd0;
                    if (pending_q | req) begin
                        // Back-to-back frame; a request arriving alongside an
                        // already pending one stays queued for the frame after.
                        hour_d    = i_hour;
                        min_d     = i_min;
                        sec_d     = i_sec;
                        msec_d    = i_msec;
                        state_d   = CONVERT;
                        pending_d = pending_q & req;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) idx_d = idx_q + 4'd1;
                    if (req) begin
                        if (pending_q) overrun_d = 1'b1;
                        else           pending_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte mux: the short frame skips the ".CC" slots by remapping its tail.
    always_comb begin
        byte_idx = idx_q;
        if (!SEND_CSEC && (idx_q >= 4'd8)) byte_idx = idx_q + 4'd3;
        case (byte_idx)
            4'd0:    frame_byte = ASCII_ZERO + {4'b0000, dig_q[0]};
            4'd1:    frame_byte = ASCII_ZERO + {4'b0000, dig_q[1]};
            4'd2:    frame_byte = ASCII_COLON;
            4'd3:    frame_byte = ASCII_ZERO + {4'b0000, dig_q[2]};
            4'd4:    frame_byte = ASCII_ZERO + {4'b0000, dig_q[3]};
            4'd5:    frame_byte = ASCII_COLON;
            4'd6:    frame_byte = ASCII_ZERO + {4'b0000, dig_q[4]};
            4'd7:    frame_byte = ASCII_ZERO + {4'b0000, dig_q[5]};
            4'd8:    frame_byte = ASCII_DOT;
            4'd9:    frame_byte = ASCII_ZERO + {4'b0000, dig_q[6]};
            4'd10:   frame_byte = ASCII_ZERO + {4'b0000, dig_q[7]};
            4'd11:   frame_byte = ASCII_CR;
            4'd12:   frame_byte = ASCII_LF;
            default: frame_byte = 8'h00;
        endcase
    end

    assign o_tx_valid = (state_q == SEND);
    assign o_tx_data  = o_tx_valid ? frame_byte : 8'h00;
    assign o_busy     = (state_q != IDLE);
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_watch_time_reporter.sv
// Self-checking bench for watch_time_reporter: table vectors, random frames against
// a formatting model, and directed backpressure / pending / auto / reset sequences.
module tb_watch_time_reporter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_report, a_ready;
    logic [4:0] a_hour;
    logic [5:0] a_min, a_sec;
    logic [6:0] a_msec;
    logic [7:0] a_data;
    logic       a_valid, a_busy, a_ovr;

    logic       b_report, b_ready;
    logic [4:0] b_hour;
    logic [5:0] b_min, b_sec;
    logic [6:0] b_msec;
    logic [7:0] b_data;
    logic       b_valid, b_busy, b_ovr;

    watch_time_reporter #(.SEND_CSEC(1'b1), .AUTO_SEC(1'b0)) dut_a (
        .clk(clk), .reset(rst_n), .i_report(a_report),
        .i_hour(a_hour), .i_min(a_min), .i_sec(a_sec), .i_msec(a_msec),
        .o_tx_data(a_data), .o_tx_valid(a_valid), .i_tx_ready(a_ready),
        .o_busy(a_busy), .o_overrun(a_ovr)
    );

    watch_time_reporter #(.SEND_CSEC(1'b0), .AUTO_SEC(1'b1)) dut_b (
        .clk(clk), .reset(rst_n), .i_report(b_report),
        .i_hour(b_hour), .i_min(b_min), .i_sec(b_sec), .i_msec(b_msec),
        .o_tx_data(b_data), .o_tx_valid(b_valid), .i_tx_ready(b_ready),
        .o_busy(b_busy), .o_overrun(b_ovr)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ovr_cnt  = 0;
    logic [7:0] rx_a[$];
    logic [7:0] rx_b[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [4:0]   h;
        logic [5:0]   m;
        logic [5:0]   s;
        logic [6:0]   c;
        logic [103:0] txt;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record this cycle's handshakes, then advance to just after the next rising edge.
    task automatic step();
        if (a_valid && a_ready) rx_a.push_back(a_data);
        if (b_valid && b_ready) rx_b.push_back(b_data);
        if (a_ovr) ovr_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic push_field(input int v);
        int t;
        t = (v > 99) ? 99 : v;
        exp_q.push_back(8'(8'h30 + t / 10));
        exp_q.push_back(8'(8'h30 + t % 10));
    endtask

    // Reference formatting: the frame text for one set of time values.
    task automatic add_exp(input int h, input int m, input int s, input int c, input bit csec);
        push_field(h);
        exp_q.push_back(8'h3A);
        push_field(m);
        exp_q.push_back(8'h3A);
        push_field(s);
        if (csec) begin
            exp_q.push_back(8'h2E);
            push_field(c);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic lit_exp(input logic [103:0] txt, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(txt[8*(n-1-i) +: 8]);
    endtask

    task automatic cmp_bytes(input string name, input logic [7:0] got[$]);
        int bad;
        bad = -1;
        chk({name, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (bad < 0 && got[i] !== exp_q[i]) bad = i;
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: byte %0d got %02h expected %02h", name, bad, got[bad], exp_q[bad]);
        end
    endtask

    task automatic scramble_a();
        a_hour = 5'($urandom_range(0, 31));
        a_min  = 6'($urandom_range(0, 63));
        a_sec  = 6'($urandom_range(0, 63));
        a_msec = 7'($urandom_range(0, 127));
    endtask

    task automatic set_a(input int h, input int m, input int s, input int c);
        a_hour = 5'(h);
        a_min  = 6'(m);
        a_sec  = 6'(s);
        a_msec = 7'(c);
    endtask

    // Run A until idle, scrambling inputs (snapshot must be immune); counts valid cycles.
    task automatic wait_idle(input string name, input bit rnd_ready, output int vcyc);
        vcyc = 0;
        for (int t = 0; t < 300; t++) begin
            if (!a_busy) break;
            if (a_valid) vcyc++;
            a_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            scramble_a();
            step();
        end
        chk({name, "_done"}, 32'(a_busy), 32'd0);
    endtask

    // Pulse a report on A; returns one cycle after the request edge.
    task automatic kick_a();
        a_report = 1'b1;
        step();
        a_report = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcyc, o0, stall, hh, mm, ss, cc;
        logic tog;

        tbl[0] = '{5'd12, 6'd34, 6'd56, 7'd78,  "12:34:56.78\r\n"};
        tbl[1] = '{5'd0,  6'd0,  6'd9,  7'd127, "00:00:09.99\r\n"};
        tbl[2] = '{5'd23, 6'd59, 6'd59, 7'd99,  "23:59:59.99\r\n"};
        tbl[3] = '{5'd0,  6'd0,  6'd0,  7'd0,   "00:00:00.00\r\n"};
        tbl[4] = '{5'd31, 6'd7,  6'd40, 7'd5,   "31:07:40.05\r\n"};

        rst_n = 1'b0;
        a_report = 1'b0; a_ready = 1'b1;
        set_a(0, 0, 0, 0);
        b_report = 1'b0; b_ready = 1'b1;
        b_hour = 5'd23; b_min = 6'd59; b_sec = 6'd59; b_msec = 7'd0;
        step();
        step();
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_overrun", 32'(a_ovr), 32'd0);
        chk("rst_data", 32'(a_data), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Table vectors: latency, 13 back-to-back bytes, frame content.
        foreach (tbl[k]) begin
            rx_a.delete();
            lit_exp(tbl[k].txt, 13);
            a_ready = 1'b1;
            set_a(int'(tbl[k].h), int'(tbl[k].m), int'(tbl[k].s), int'(tbl[k].c));
            kick_a();
            scramble_a();
            chk($sformatf("tbl%0d_n1_valid", k), 32'(a_valid), 32'd0);
            chk($sformatf("tbl%0d_n1_busy", k), 32'(a_busy), 32'd1);
            step();
            chk($sformatf("tbl%0d_n2_valid", k), 32'(a_valid), 32'd1);
            chk($sformatf("tbl%0d_n2_data", k), 32'(a_data), 32'(exp_q[0]));
            wait_idle($sformatf("tbl%0d", k), 1'b0, vcyc);
            chk($sformatf("tbl%0d_send_cycles", k), 32'(vcyc), 32'd13);
            cmp_bytes($sformatf("tbl%0d_frame", k), rx_a);
            step();
        end

        // Backpressure: alternating ready with a 5-cycle stall on the first colon.
        rx_a.delete();
        exp_q.delete();
        add_exp(9, 5, 0, 7, 1'b1);
        set_a(9, 5, 0, 7);
        a_ready = 1'b0;
        kick_a();
        tog = 1'b1;
        stall = 5;
        for (int t = 0; t < 300; t++) begin
            if (!a_busy) break;
            if (a_valid && rx_a.size() == 2 && stall > 0) begin
                a_ready = 1'b0;
                chk("bp_hold_data", 32'(a_data), 32'h3A);
                stall--;
            end else begin
                a_ready = tog;
                tog = ~tog;
            end
            scramble_a();
            step();
        end
        chk("bp_done", 32'(a_busy), 32'd0);
        chk("bp_stall_seen", 32'(stall), 32'd0);
        cmp_bytes("bp_frame", rx_a);
        a_ready = 1'b1;
        step();

        // Pending then overrun mid-frame; second frame uses last-byte-cycle inputs.
        rx_a.delete();
        exp_q.delete();
        add_exp(1, 2, 3, 4, 1'b1);
        add_exp(5, 6, 7, 8, 1'b1);
        set_a(1, 2, 3, 4);
        o0 = ovr_cnt;
        kick_a();
        for (int k = 1; k < 300; k++) begin
            if (!a_busy) break;
            a_report = (k == 4 || k == 7);
            if (a_valid && rx_a.size() == 12) set_a(5, 6, 7, 8);
            else scramble_a();
            step();
        end
        a_report = 1'b0;
        chk("pend_done", 32'(a_busy), 32'd0);
        cmp_bytes("pend_frames", rx_a);
        chk("pend_overrun_pulses", 32'(ovr_cnt - o0), 32'd1);
        step();

        // Random frames with random ready against the formatting model.
        for (int r = 0; r < 20; r++) begin
            rx_a.delete();
            exp_q.delete();
            hh = $urandom_range(0, 31);
            mm = $urandom_range(0, 63);
            ss = $urandom_range(0, 63);
            cc = $urandom_range(0, 127);
            add_exp(hh, mm, ss, cc, 1'b1);
            set_a(hh, mm, ss, cc);
            a_ready = ($urandom_range(0, 1) != 0);
            kick_a();
            wait_idle($sformatf("rnd%0d", r), 1'b1, vcyc);
            cmp_bytes($sformatf("rnd%0d_frame", r), rx_a);
            a_ready = 1'b1;
            step();
        end

        // Auto mode: no frames while i_sec holds, one short frame on the rollover.
        chk("auto_quiet_bytes", 32'(rx_b.size()), 32'd0);
        chk("auto_quiet_busy", 32'(b_busy), 32'd0);
        b_hour = 5'd0; b_min = 6'd0; b_sec = 6'd0;
        for (int t = 0; t < 30; t++) begin
            b_msec = 7'($urandom_range(0, 99));
            step();
        end
        lit_exp("00:00:00\r\n", 10);
        cmp_bytes("auto_frame", rx_b);
        for (int t = 0; t < 30; t++) step();
        chk("auto_hold_no_more", 32'(rx_b.size()), 32'd10);
        chk("auto_hold_busy", 32'(b_busy), 32'd0);

        // Reset mid-frame with a pending request: nothing resumes afterwards.
        rx_a.delete();
        set_a(12, 34, 56, 78);
        a_ready = 1'b1;
        kick_a();
        for (int t = 0; t < 50; t++) begin
            if (rx_a.size() == 5) break;
            a_report = (t == 3);
            step();
        end
        a_report = 1'b0;
        chk("rst_mid_at_byte5", 32'(rx_a.size()), 32'd5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_valid", 32'(a_valid), 32'd0);
        chk("rst_mid_busy", 32'(a_busy), 32'd0);
        chk("rst_mid_data", 32'(a_data), 32'd0);
        vcyc = 0;
        for (int t = 0; t < 20; t++) begin
            if (a_valid || a_busy) vcyc++;
            step();
        end
        chk("rst_mid_no_resume", 32'(vcyc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
